// File: rtl/game_sequencer_if.sv
// Control/status bundle between the game_sequencer and the rest of the core.
// master drives the game inputs; slave is the sequencer side.
interface game_sequencer_if;
  localparam int unsigned DIFF_W  = 2;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SPEED_W = 4;
  localparam int unsigned SCORE_W = 16;

  logic               frame_tick;
  logic               start_btn;
  logic               collision;
  logic [DIFF_W-1:0]  difficulty;
  logic               gameover;
  logic               countdown_active;
  logic               playing;
  logic [CNT_W-1:0]   countdown_remaining;
  logic [SPEED_W-1:0] speed;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] best_score;

  modport master (
    output frame_tick, start_btn, collision, difficulty,
    input  gameover, countdown_active, playing, countdown_remaining,
           speed, score, best_score
  );

  modport slave (
    input  frame_tick, start_btn, collision, difficulty,
    output gameover, countdown_active, playing, countdown_remaining,
           speed, score, best_score
  );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow controller: GAMEOVER -> COUNTDOWN -> PLAYING, speed ramp, score, best scores.
// Define GAME_SEQUENCER_PAUSE_EN to add a PAUSED state toggled by the start button.
module game_sequencer #(
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned RAMP_FRAMES      = 600
) (
  input  logic            clk,
  input  logic            reset,
  game_sequencer_if.slave bus
);
  localparam int unsigned DIFF_W  = 2;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SPEED_W = 4;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned RAMP_W  = 16;
  localparam int unsigned N_DIFF  = 4;

  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(15);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(16'hFFFF);

  typedef enum logic [1:0] {
    ST_GAMEOVER,
    ST_COUNTDOWN,
    ST_PLAYING
`ifdef GAME_SEQUENCER_PAUSE_EN
    , ST_PAUSED
`endif
  } state_t;

  state_t              state, state_nx;
  logic                start_q, rise_q, start_rise_c;
  logic [DIFF_W-1:0]   diff_q, diff_nx;
  logic [CNT_W-1:0]    cnt_q, cnt_nx;
  logic [SPEED_W-1:0]  speed_q, speed_nx;
  logic [SCORE_W-1:0]  score_q, score_nx;
  logic [RAMP_W-1:0]   ramp_q, ramp_nx, ramp_inc_c;
  logic [SCORE_W-1:0]  best_q [N_DIFF];
  logic                best_we_c;
  logic                gameover_q, countdown_q, playing_q;
  logic [SCORE_W-1:0]  best_score_q;

  // Edge register: the rise is itself registered, giving a 2-cycle start latency.
  assign start_rise_c = bus.start_btn & ~start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      start_q <= bus.start_btn;
      rise_q  <= start_rise_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_GAMEOVER;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_GAMEOVER:  if (rise_q) state_nx = ST_COUNTDOWN;
      ST_COUNTDOWN: if (bus.frame_tick && cnt_q == CNT_W'(1)) state_nx = ST_PLAYING;
      ST_PLAYING: begin
        if (bus.collision) state_nx = ST_GAMEOVER;
`ifdef GAME_SEQUENCER_PAUSE_EN
        else if (rise_q) state_nx = ST_PAUSED;
`endif
      end
`ifdef GAME_SEQUENCER_PAUSE_EN
      ST_PAUSED:    if (rise_q) state_nx = ST_PLAYING;
`endif
      default:      state_nx = ST_GAMEOVER;
    endcase
  end

  assign ramp_inc_c = ramp_q + RAMP_W'(1);

  // Datapath next values; PAUSED falls through to the hold defaults.
  always_comb begin
    diff_nx   = diff_q;
    cnt_nx    = cnt_q;
    speed_nx  = speed_q;
    score_nx  = score_q;
    ramp_nx   = ramp_q;
    best_we_c = 1'b0;
    case (state)
      ST_GAMEOVER: begin
        if (rise_q) begin
          diff_nx  = bus.difficulty;
          score_nx = '0;
          cnt_nx   = CNT_W'(COUNTDOWN_FRAMES);
        end
      end
      ST_COUNTDOWN: begin
        if (bus.frame_tick) begin
          cnt_nx = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            speed_nx = SPEED_W'({diff_q, 1'b0}) + SPEED_W'(2);
            ramp_nx  = '0;
          end
        end
      end
      ST_PLAYING: begin
        if (bus.collision) begin
          speed_nx  = '0;
          best_we_c = 1'b1;
        end else if (bus.frame_tick) begin
          if (score_q != SCORE_MAX) score_nx = score_q + SCORE_W'(1);
          if (ramp_inc_c == RAMP_W'(RAMP_FRAMES)) begin
            ramp_nx = '0;
            if (speed_q != SPEED_MAX) speed_nx = speed_q + SPEED_W'(1);
          end else begin
            ramp_nx = ramp_inc_c;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      diff_q      <= '0;
      cnt_q       <= '0;
      speed_q     <= '0;
      score_q     <= '0;
      ramp_q      <= '0;
      gameover_q  <= 1'b1;
      countdown_q <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      diff_q      <= diff_nx;
      cnt_q       <= cnt_nx;
      speed_q     <= speed_nx;
      score_q     <= score_nx;
      ramp_q      <= ramp_nx;
      gameover_q  <= (state_nx == ST_GAMEOVER);
      countdown_q <= (state_nx == ST_COUNTDOWN);
`ifdef GAME_SEQUENCER_PAUSE_EN
      playing_q   <= (state_nx == ST_PLAYING) || (state_nx == ST_PAUSED);
`else
      playing_q   <= (state_nx == ST_PLAYING);
`endif
    end
  end

  // Best scores; display follows the live difficulty selector.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(N_DIFF); i++) best_q[i] <= '0;
      best_score_q <= '0;
    end else begin
      if (best_we_c && score_q > best_q[diff_q]) best_q[diff_q] <= score_q;
      best_score_q <= best_q[bus.difficulty];
    end
  end

  assign bus.gameover            = gameover_q;
  assign bus.countdown_active    = countdown_q;
  assign bus.playing             = playing_q;
  assign bus.countdown_remaining = cnt_q;
  assign bus.speed               = speed_q;
  assign bus.score               = score_q;
  assign bus.best_score          = best_score_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: one short-countdown instance, one default-parameter instance.
module tb_game_sequencer;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  game_sequencer_if bus0 ();
  game_sequencer_if bus1 ();

  game_sequencer #(.COUNTDOWN_FRAMES(3), .RAMP_FRAMES(600)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  game_sequencer u_dflt (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  assign bus1.frame_tick = bus0.frame_tick;
  assign bus1.start_btn  = bus0.start_btn;
  assign bus1.collision  = bus0.collision;
  assign bus1.difficulty = bus0.difficulty;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus0.frame_tick = 1'b1;
      cyc();
    end
    bus0.frame_tick = 1'b0;
  endtask

  // Rising edge then release; after the second edge the DUT is in COUNTDOWN.
  task automatic press();
    bus0.start_btn = 1'b1;
    cyc();
    bus0.start_btn = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".gameover"},  32'(bus0.gameover), 32'd1);
    check({tag, ".countdown"}, 32'(bus0.countdown_active), 32'd0);
    check({tag, ".playing"},   32'(bus0.playing), 32'd0);
    check({tag, ".remaining"}, 32'(bus0.countdown_remaining), 32'd0);
    check({tag, ".speed"},     32'(bus0.speed), 32'd0);
    check({tag, ".score"},     32'(bus0.score), 32'd0);
    check({tag, ".best"},      32'(bus0.best_score), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus0.frame_tick = 1'b0;
    bus0.start_btn  = 1'b0;
    bus0.collision  = 1'b0;
    bus0.difficulty = 2'd2;
    cyc();
    do_reset();
    cyc();
    check_reset_outputs("rst");

    // Held start button: exactly one transition, 2-cycle latency.
    bus0.start_btn = 1'b1;
    cyc();
    check("start.cyc1", 32'(bus1.countdown_active), 32'd0);
    cyc();
    check("start.cyc2", 32'(bus1.countdown_active), 32'd1);
    check("start.rem180", 32'(bus1.countdown_remaining), 32'd180);
    check("start.rem3", 32'(bus0.countdown_remaining), 32'd3);
    for (int i = 0; i < 8; i++) cyc();
    bus0.start_btn = 1'b0;
    check("hold.countdown", 32'(bus1.countdown_active), 32'd1);
    check("hold.rem180", 32'(bus1.countdown_remaining), 32'd180);
    check("hold.gameover", 32'(bus1.gameover), 32'd0);

    ticks(2);
    check("cd.rem1", 32'(bus0.countdown_remaining), 32'd1);
    check("cd.notplaying", 32'(bus0.playing), 32'd0);
    ticks(1);
    check("cd.playing", 32'(bus0.playing), 32'd1);
    check("cd.speed6", 32'(bus0.speed), 32'd6);
    check("cd.rem0", 32'(bus0.countdown_remaining), 32'd0);
    check("cd.score0", 32'(bus0.score), 32'd0);

    // Speed ramp and saturation.
    ticks(599);
    check("ramp.599", 32'(bus0.speed), 32'd6);
    ticks(1);
    check("ramp.600", 32'(bus0.speed), 32'd7);
    check("ramp.score", 32'(bus0.score), 32'd600);
    ticks(6000);
    check("ramp.sat", 32'(bus0.speed), 32'd15);
    check("ramp.score2", 32'(bus0.score), 32'd6600);

    do_reset();
    check_reset_outputs("rst.play");

    // 100-frame game sets best for difficulty 2.
    press();
    ticks(3);
    ticks(100);
    check("g100.score", 32'(bus0.score), 32'd100);
    bus0.collision = 1'b1;
    cyc();
    bus0.collision = 1'b0;
    check("g100.gameover", 32'(bus0.gameover), 32'd1);
    check("g100.playing", 32'(bus0.playing), 32'd0);
    check("g100.speed0", 32'(bus0.speed), 32'd0);
    check("g100.final", 32'(bus0.score), 32'd100);
    check("g100.best_lat", 32'(bus0.best_score), 32'd0);
    cyc();
    check("g100.best", 32'(bus0.best_score), 32'd100);

    // Collision in GAMEOVER ignored.
    bus0.collision = 1'b1;
    cyc();
    bus0.collision = 1'b0;
    check("go.coll", 32'(bus0.gameover), 32'd1);

    // 50-frame game; collision during countdown ignored.
    press();
    check("g50.cleared", 32'(bus0.score), 32'd0);
    bus0.collision = 1'b1;
    cyc();
    bus0.collision = 1'b0;
    check("g50.cd_coll", 32'(bus0.countdown_active), 32'd1);
    check("g50.cd_go", 32'(bus0.gameover), 32'd0);
    ticks(3);
    ticks(50);
    bus0.collision = 1'b1;
    cyc();
    bus0.collision = 1'b0;
    cyc();
    check("g50.score", 32'(bus0.score), 32'd50);
    check("g50.best", 32'(bus0.best_score), 32'd100);

    // Collision coincident with a tick at score 99.
    press();
    ticks(3);
    ticks(99);
    bus0.collision  = 1'b1;
    bus0.frame_tick = 1'b1;
    cyc();
    bus0.collision  = 1'b0;
    bus0.frame_tick = 1'b0;
    check("g99.score", 32'(bus0.score), 32'd99);
    check("g99.gameover", 32'(bus0.gameover), 32'd1);
    cyc();
    check("g99.best", 32'(bus0.best_score), 32'd100);

    // Display follows the live selector.
    bus0.difficulty = 2'd0;
    cyc();
    check("sel.d0", 32'(bus0.best_score), 32'd0);
    bus0.difficulty = 2'd2;
    cyc();
    check("sel.d2", 32'(bus0.best_score), 32'd100);

    // Reset mid-PLAYING clears best registers too.
    press();
    ticks(3);
    ticks(13);
    check("mid.playing", 32'(bus0.playing), 32'd1);
    do_reset();
    check_reset_outputs("rst.mid");
    cyc();
    check("mid.best_cleared", 32'(bus0.best_score), 32'd0);

`ifdef GAME_SEQUENCER_PAUSE_EN
    press();
    ticks(3);
    ticks(5);
    press();
    ticks(20);
    bus0.collision = 1'b1;
    cyc();
    bus0.collision = 1'b0;
    check("pause.score", 32'(bus0.score), 32'd5);
    check("pause.playing", 32'(bus0.playing), 32'd1);
    check("pause.gameover", 32'(bus0.gameover), 32'd0);
    press();
    ticks(1);
    check("resume.score", 32'(bus0.score), 32'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
